// File: rtl/irrigation_sensor_conditioner.sv
// rtl/irrigation_sensor_conditioner.sv - sensor sync/debounce/validate/classify stage
//
// Synchronizes and debounces the raw tank-level and soil-humidity contacts,
// checks the thermometer codes, and once per 1 Hz tick classifies them into
// the irrigation request consumed by the main state machine.
//
// Ports:
//   _50_MHz          in   system clock, rising edge
//   rst_n            in   synchronous active-low reset
//   _1_Hz            in   1 Hz square wave, rising edge = sample tick (async)
//   level_sensors    in   [2:0] tank contacts {high, mid, low}, 1 = submerged (async)
//   humidity_sensors in   [1:0] soil contacts {wet, moist} (async)
//   irrigation_data  out  [1:0] 00 none, 01 drip, 10 sprinkler, 11 no water / fault
//   specific         out  water-limited cycle request
//   sensor_error     out  high while not in NORMAL
//   data_changed     out  one-clock pulse when irrigation_data/specific change
module irrigation_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int RECOVER_TICKS   = 3
) (
  input  logic       _50_MHz,
  input  logic       rst_n,
  input  logic       _1_Hz,
  input  logic [2:0] level_sensors,
  input  logic [1:0] humidity_sensors,
  output logic [1:0] irrigation_data,
  output logic       specific,
  output logic       sensor_error,
  output logic       data_changed
);

  localparam int                REC_W    = (RECOVER_TICKS < 2) ? 1 : $clog2(RECOVER_TICKS + 1);
  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [REC_W-1:0]  REC_LAST = REC_W'(RECOVER_TICKS - 1);
  localparam logic [REC_W-1:0]  REC_ONE  = REC_W'(1);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers: bit 5 is the 1 Hz wave, [4:2] level, [1:0] humidity
  // ---------------------------------------------------------------------------
  logic [5:0] raw_in;
  logic [5:0] sync1;
  logic [5:0] sync2;
  logic       hz_prev;
  logic       tick;

  assign raw_in = {_1_Hz, level_sensors, humidity_sensors};

  always_ff @(posedge _50_MHz) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      hz_prev <= 1'b0;
    end else begin
      sync1   <= raw_in;
      sync2   <= sync1;
      hz_prev <= sync2[5];
    end
  end

  assign tick = sync2[5] & ~hz_prev;

  // ---------------------------------------------------------------------------
  // Per-bit debounce: a bit must disagree with its filtered value for
  // DEBOUNCE_CYCLES consecutive clocks before the filtered value follows it.
  // ---------------------------------------------------------------------------
  logic [4:0]       filt;
  logic [CNT_W-1:0] db_cnt [5];

  always_ff @(posedge _50_MHz) begin
    if (!rst_n) begin
      filt <= '0;
      for (int i = 0; i < 5; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] != filt[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            filt[i]   <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_ONE;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Code validation and classification of the filtered contacts
  // ---------------------------------------------------------------------------
  logic [2:0] lvl;
  logic [1:0] hum;
  logic       codes_ok;
  logic [1:0] cls_data;
  logic       cls_spec;

  assign lvl      = filt[4:2];
  assign hum      = filt[1:0];
  assign codes_ok = ((lvl == 3'b000) || (lvl == 3'b001) || (lvl == 3'b011) || (lvl == 3'b111))
                    && (hum != 2'b10);

  always_comb begin
    cls_data = 2'b10;
    if (lvl == 3'b000) begin
      cls_data = 2'b11;
    end else if (hum == 2'b11) begin
      cls_data = 2'b00;
    end else if (hum == 2'b01) begin
      cls_data = 2'b01;
    end else if (lvl == 3'b001) begin
      cls_data = 2'b01;
    end else begin
      cls_data = 2'b10;
    end
    cls_spec = (lvl == 3'b001) && ((cls_data == 2'b01) || (cls_data == 2'b10));
  end

  // ---------------------------------------------------------------------------
  // Fault FSM: state register / next-state logic / output logic
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;

  always_ff @(posedge _50_MHz) begin
    if (!rst_n) begin
      state_q   <= ST_NORMAL;
      rec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    if (tick) begin
      case (state_q)
        ST_NORMAL: begin
          if (!codes_ok) state_d = ST_FAULT;
        end
        ST_FAULT: begin
          if (codes_ok) begin
            if (RECOVER_TICKS == 1) begin
              state_d = ST_NORMAL;
            end else begin
              state_d   = ST_RECOVER;
              rec_cnt_d = REC_ONE;
            end
          end
        end
        ST_RECOVER: begin
          if (!codes_ok) begin
            state_d   = ST_FAULT;
            rec_cnt_d = '0;
          end else if (rec_cnt_q == REC_LAST) begin
            state_d   = ST_NORMAL;
            rec_cnt_d = '0;
          end else begin
            rec_cnt_d = rec_cnt_q + REC_ONE;
          end
        end
        default: begin
          state_d   = ST_NORMAL;
          rec_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs follow the state being entered on this tick, so the entering-fault
  // tick already reports the fault and the leaving-recover tick already
  // reports the fresh classification.
  logic [1:0] data_d;
  logic       spec_d;
  logic       err_d;

  always_comb begin
    data_d = irrigation_data;
    spec_d = specific;
    err_d  = sensor_error;
    if (tick) begin
      if (state_d == ST_NORMAL) begin
        data_d = cls_data;
        spec_d = cls_spec;
        err_d  = 1'b0;
      end else begin
        data_d = 2'b11;
        spec_d = 1'b0;
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge _50_MHz) begin
    if (!rst_n) begin
      irrigation_data <= 2'b00;
      specific        <= 1'b0;
      sensor_error    <= 1'b0;
      data_changed    <= 1'b0;
    end else begin
      irrigation_data <= data_d;
      specific        <= spec_d;
      sensor_error    <= err_d;
      data_changed    <= tick && ({data_d, spec_d} != {irrigation_data, specific});
    end
  end

endmodule

// File: tb/tb_irrigation_sensor_conditioner.sv
// tb/tb_irrigation_sensor_conditioner.sv - self-checking bench for irrigation_sensor_conditioner
module tb_irrigation_sensor_conditioner;

  localparam int DB = 4;
  localparam int RT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hz;
  logic [2:0] level;
  logic [1:0] hum;
  logic [1:0] irrigation_data;
  logic       specific;
  logic       sensor_error;
  logic       data_changed;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  irrigation_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (4),
    .RECOVER_TICKS  (RT)
  ) dut (
    ._50_MHz         (clk),
    .rst_n           (rst_n),
    ._1_Hz           (hz),
    .level_sensors   (level),
    .humidity_sensors(hum),
    .irrigation_data (irrigation_data),
    .specific        (specific),
    .sensor_error    (sensor_error),
    .data_changed    (data_changed)
  );

  // Behavioural model: inputs delayed two clocks, a bit is accepted once the
  // last DB delayed samples all disagree with the accepted value, and a fault
  // clears after RT consecutive valid ticks.
  logic [5:0]    m_s1 = '0, m_s2 = '0;
  logic          m_hzd = 1'b0;
  logic [4:0]    m_filt = '0;
  logic [DB-1:0] m_hist [5];
  bit            faulted = 0;
  int            streak = 0;
  bit            model_live = 0;
  logic [1:0]    exp_data = 2'b00;
  logic          exp_spec = 1'b0, exp_err = 1'b0, exp_dc = 1'b0;

  function automatic logic [2:0] classify(input logic [2:0] l, input logic [1:0] h);
    logic [1:0] d;
    if (l == 3'b000)      d = 2'b11;
    else if (h == 2'b11)  d = 2'b00;
    else if (h == 2'b01)  d = 2'b01;
    else if (l == 3'b001) d = 2'b01;
    else                  d = 2'b10;
    return {d, (l == 3'b001) && (d == 2'b01 || d == 2'b10)};
  endfunction

  always @(posedge clk) begin : model
    logic [2:0] l;
    logic [1:0] h;
    logic [2:0] c;
    bit         ok;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_hzd = 1'b0; m_filt = '0;
      for (int b = 0; b < 5; b++) m_hist[b] = '0;
      faulted = 0; streak = 0;
      exp_data = 2'b00; exp_spec = 1'b0; exp_err = 1'b0; exp_dc = 1'b0;
      model_live = 1;
    end else begin
      exp_dc = 1'b0;
      if (m_s2[5] && !m_hzd) begin
        l  = m_filt[4:2];
        h  = m_filt[1:0];
        ok = (l inside {3'b000, 3'b001, 3'b011, 3'b111}) && (h != 2'b10);
        if (!ok) begin
          faulted = 1; streak = 0;
        end else if (faulted) begin
          streak++;
          if (streak >= RT) begin faulted = 0; streak = 0; end
        end
        c = faulted ? 3'b110 : classify(l, h);
        exp_dc   = (c != {exp_data, exp_spec});
        exp_data = c[2:1];
        exp_spec = c[0];
        exp_err  = faulted;
      end
      for (int b = 0; b < 5; b++) begin
        m_hist[b] = {m_hist[b][DB-2:0], m_s2[b]};
        if (m_hist[b] == {DB{~m_filt[b]}}) m_filt[b] = m_s2[b];
      end
      m_hzd = m_s2[5];
      m_s2  = m_s1;
      m_s1  = {hz, level, hum};
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      total_cnt++;
      if ({irrigation_data, specific, sensor_error, data_changed} === {exp_data, exp_spec, exp_err, exp_dc})
        pass_cnt++;
      else
        $display("FAIL model_cmp t=%0t got data=%b spec=%b err=%b dc=%b want data=%b spec=%b err=%b dc=%b",
                 $time, irrigation_data, specific, sensor_error, data_changed,
                 exp_data, exp_spec, exp_err, exp_dc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s got %0d want %0d", name, act, exp);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 1 Hz period compressed to 8 clocks; counts data_changed pulses seen.
  task automatic do_tick(output int dc_seen);
    dc_seen = 0;
    @(negedge clk);
    hz = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) hz = 1'b0;
      @(negedge clk);
      if (data_changed === 1'b1) dc_seen++;
    end
  endtask

  int dc;

  initial begin
    rst_n = 1'b0; hz = 1'b0; level = 3'b111; hum = 2'b00;
    settle(3);
    check("rst_data", irrigation_data, 0);
    check("rst_spec", specific, 0);
    check("rst_err", sensor_error, 0);
    check("rst_dc", data_changed, 0);

    // first tick: full tank, dry soil -> sprinkler
    rst_n = 1'b1;
    settle(8);
    do_tick(dc);
    check("t1_data", irrigation_data, 2);
    check("t1_spec", specific, 0);
    check("t1_err", sensor_error, 0);
    check("t1_dc_pulses", dc, 1);

    // low tank while dry -> drip, limited
    level = 3'b001;
    settle(10); do_tick(dc);
    check("t2_data", irrigation_data, 1);
    check("t2_spec", specific, 1);
    hum = 2'b11;
    settle(10); do_tick(dc);
    check("t2_wet_data", irrigation_data, 0);
    check("t2_wet_spec", specific, 0);

    // debounce: 3-clock glitch rejected, held change accepted
    level = 3'b111; hum = 2'b00;
    settle(10); do_tick(dc);
    check("t3_base", irrigation_data, 2);
    hum = 2'b01; settle(3); hum = 2'b00;
    settle(10); do_tick(dc);
    check("t3_glitch_data", irrigation_data, 2);
    check("t3_glitch_dc", dc, 0);
    hum = 2'b01;
    settle(8); do_tick(dc);
    check("t3_held_data", irrigation_data, 1);
    check("t3_held_dc", dc, 1);

    // fault and recovery
    level = 3'b101;
    settle(10); do_tick(dc);
    check("t4_fault_data", irrigation_data, 3);
    check("t4_fault_err", sensor_error, 1);
    level = 3'b111; hum = 2'b00;
    settle(10); do_tick(dc); do_tick(dc);
    check("t4_rec2_data", irrigation_data, 3);
    check("t4_rec2_err", sensor_error, 1);
    do_tick(dc);
    check("t4_rec3_data", irrigation_data, 2);
    check("t4_rec3_err", sensor_error, 0);

    // recovery aborted by invalid humidity
    level = 3'b101;
    settle(10); do_tick(dc);
    level = 3'b111;
    settle(10); do_tick(dc); do_tick(dc);
    check("t5_rec_err", sensor_error, 1);
    hum = 2'b10;
    settle(10); do_tick(dc);
    check("t5_abort_data", irrigation_data, 3);
    check("t5_abort_err", sensor_error, 1);
    hum = 2'b00;
    settle(10); do_tick(dc); do_tick(dc);
    check("t5_two_valid_err", sensor_error, 1);
    do_tick(dc);
    check("t5_back_data", irrigation_data, 2);
    check("t5_back_err", sensor_error, 0);

    // reset during RECOVER
    level = 3'b101;
    settle(10); do_tick(dc);
    level = 3'b111;
    settle(10); do_tick(dc);
    check("t6_in_recover", sensor_error, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_data", irrigation_data, 0);
    check("t6_rst_err", sensor_error, 0);
    check("t6_rst_spec", specific, 0);
    rst_n = 1'b1; level = 3'b000;
    settle(10); do_tick(dc);
    check("t6_empty_data", irrigation_data, 3);
    check("t6_empty_spec", specific, 0);
    check("t6_empty_err", sensor_error, 0);
    check("t6_empty_dc", dc, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/irrigation_sensor_conditioner.md
# irrigation_sensor_conditioner

- Upstream stage of the irrigation state-machine group.
- Takes raw tank-level and soil-humidity sensor contacts, synchronizes and debounces them, and validates the thermometer codes.
- Once per `_1_Hz` tick, classifies the result into the `irrigation_data[1:0]` and `specific` inputs that the main state machine and preset generator consume.
- Invalid sensor codes hold the output in a fault code until the sensors read valid for several consecutive seconds.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive clocks a synchronized input must differ from its filtered value before the filtered value is updated. Minimum 2.
- `CNT_W`, default 16: debounce counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `RECOVER_TICKS`, default 3: consecutive valid ticks needed to leave fault. Minimum 1.
- `_50_MHz` in 1: system clock. Everything is on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `_1_Hz` in 1: 1 Hz square wave. Each rising edge is a sample tick.
- `level_sensors` in 3: asynchronous tank contacts {high, mid, low}. 1 means submerged.
- `humidity_sensors` in 2: asynchronous soil contacts {wet, moist}.
- `irrigation_data` out 2:
  - 00 = none
  - 01 = drip
  - 10 = sprinkler
  - 11 = no water / fault
- `specific` out 1: water-limited cycle request to the preset generator.
- `sensor_error` out 1: high while FSM is not NORMAL.
- `data_changed` out 1: one-clock pulse when `irrigation_data` or `specific` changes value.

## Operation
- **Synchronization:** every sensor bit and `_1_Hz` pass through a 2-flop synchronizer.
- **Tick detection:** `tick` = synchronized `_1_Hz` is 1 this cycle and was 0 the previous cycle.
- **Debounce, per bit** (5 independent counters):
  - If sync ≠ filt: count increments.
  - When count = DEBOUNCE_CYCLES−1 and the bits still differ: filt ← sync, count ← 0.
  - If sync = filt: count ← 0.
- **Valid level codes** (filtered {h,m,l}): 000 empty, 001 low, 011 mid, 111 full. All other codes are invalid.
- **Valid humidity codes** (filtered {w,m}): 00 dry, 01 moist, 11 wet. 10 is invalid.
- **Classification**, first matching rule wins:
  - Level empty → data 11, specific 0.
  - Wet → 00, specific 0.
  - Moist → 01.
  - Dry with level low → 01.
  - Dry otherwise → 10.
  - `specific` = 1 iff level = low (001) and data ∈ {01, 10}.
- **FSM**, evaluated only on `tick`; no state change without a tick:
  - **NORMAL:** any invalid code → FAULT. Otherwise outputs ← classification.
  - **FAULT:** outputs 11 / 0 / error 1. All codes valid → RECOVER with rec_cnt = 1, or directly to NORMAL with outputs ← classification if RECOVER_TICKS = 1.
  - **RECOVER:** outputs held at fault values.
    - Invalid code → FAULT, rec_cnt ← 0.
    - Valid code with rec_cnt+1 = RECOVER_TICKS → NORMAL, outputs ← classification on this same tick.
    - Valid code otherwise → rec_cnt increments.
- **`sensor_error`** = 1 in FAULT and RECOVER, including the update on the tick that enters FAULT.
- **Reset** (`rst_n` low at a clock edge):
  - Outputs: `irrigation_data` 00, `specific` 0, `sensor_error` 0, `data_changed` 0.
  - Internal: synchronizers and filtered bits 0, counters 0, FSM NORMAL, rec_cnt 0.
  - Reset mid-debounce or mid-RECOVER discards all progress.

## Timing
- Outputs are registered and update only in the clock after the `tick` cycle; they hold between ticks.
- `data_changed` is high for exactly that one clock, and only if the value differs from the previous one.
- Latency from a clean input step to the filtered value: 2 (sync) + DEBOUNCE_CYCLES clocks.
- A step is visible at the outputs on the first tick after the filtered value updates.
- `_1_Hz` rising edge to output update: 3 clocks (2 sync, 1 detect/register).
- A glitch shorter than DEBOUNCE_CYCLES clocks never reaches the filtered value.
- Debounce completing in the same cycle as `tick`: the tick uses the old filtered value.
- Two ticks are always more than 2 clocks apart, so no back-to-back tick handling is required.

## Test plan
Sim parameters: DEBOUNCE_CYCLES = 4, RECOVER_TICKS = 3.

1. **Reset then first tick:** release reset with levels 111, humidity 00, wait 8 clocks, pulse tick → data 10, specific 0, error 0, `data_changed` 1 for one clock.
2. **Low tank while dry:** level 001, humidity 00 → data 01, specific 1. Then humidity 11 → data 00, specific 0.
3. **Debounce:** toggle humidity bit 0 for 3 clocks and return, then tick → no output change. Hold the bit for 6 or more clocks, then tick → output reflects the new value.
4. **Fault and recovery:**
   - Level 101, tick → data 11, error 1.
   - Level 111 for 2 ticks → still 11, error 1.
   - Third valid tick → data 10, error 0.
5. **Recovery aborted:** inside RECOVER, after 2 valid ticks apply humidity 10 → FAULT. 3 further valid ticks are then needed before returning to NORMAL.
6. **Mid-operation reset:** assert `rst_n` low during RECOVER → next clock: all outputs 0, FSM NORMAL. Empty tank (000) on the next tick → data 11, error 0.
